// File: rtl/uart_rx_if.sv
// Receive-side bundle of the 8N1 UART: the serial pin plus the recovered byte and its status strobes.
// master is the receiver; slave is whatever drives the line and consumes the bytes.
interface uart_rx_if;
    logic       uart_rx;
    logic [7:0] uart_rx_data;
    logic       uart_rx_done;
    logic       uart_rx_busy;
    logic       uart_rx_frame_err;

    modport master (
        input  uart_rx,
        output uart_rx_data,
        output uart_rx_done,
        output uart_rx_busy,
        output uart_rx_frame_err
    );

    modport slave (
        output uart_rx,
        input  uart_rx_data,
        input  uart_rx_done,
        input  uart_rx_busy,
        input  uart_rx_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial pin, samples each bit once at mid-bit and
// presents the byte with a one-cycle done pulse, or a one-cycle frame_err pulse on a low stop bit.
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic      sysclk,
    input  logic      rstn,
    uart_rx_if.master rx_if
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       data_reg, data_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             rx_meta_reg, rx_s_reg, rx_d_reg;
    logic             start_edge;

    // Synchroniser flops reset high so a released reset never looks like a falling edge.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_d_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx_if.uart_rx;
            rx_s_reg    <= rx_meta_reg;
            rx_d_reg    <= rx_s_reg;
        end
    end

    assign start_edge = rx_d_reg & ~rx_s_reg;

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + CNT_W'(1);
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start_edge) state_next = START;
            end
            START: begin
                // A start bit that is high again at its midpoint was only a glitch.
                if (cnt_reg == HALF_M1) begin
                    cnt_next = '0;
                    if (rx_s_reg) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_reg == FULL_M1) begin
                    shift_next[bit_idx_reg] = rx_s_reg;
                    cnt_next                = '0;
                    bit_idx_next            = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
                if (cnt_reg == FULL_M1) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rx_s_reg) begin
                        data_next = shift_reg;
                        done_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_if.uart_rx_data      = data_reg;
    assign rx_if.uart_rx_done      = done_reg;
    assign rx_if.uart_rx_frame_err = err_reg;
    assign rx_if.uart_rx_busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: bytes are queued as they are serialised onto the line
// and popped when the receiver pulses done.
module tb_uart_rx;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    uart_rx_if bus ();
    uart_rx #(.CLK_FREQ(8), .BAUD(1)) dut (.sysclk(clk), .rstn(rstn), .rx_if(bus));

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int busy_cycles = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.uart_rx_busy) busy_cycles++;
            if (bus.uart_rx_frame_err) err_cnt++;
            if (bus.uart_rx_done || bus.uart_rx_frame_err)
                check("done_err_overlap", {31'd0, bus.uart_rx_done & bus.uart_rx_frame_err}, 0);
            if (bus.uart_rx_done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {24'd0, bus.uart_rx_data}, 32'h100);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", {24'd0, bus.uart_rx_data}, {24'd0, mon_exp});
                    $display("rx byte 0x%02h (expected 0x%02h)", bus.uart_rx_data, mon_exp);
                end
            end
        end
    end

    task automatic bit_time(input logic v);
        @(negedge clk);
        bus.uart_rx = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop_bit);
    endtask

    task automatic idle(input int n);
        bus.uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int d0, e0, b0, bl;

    initial begin
        rstn = 1'b0;
        bus.uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, bus.uart_rx_data}, 0);
        check("rst_done", {31'd0, bus.uart_rx_done}, 0);
        check("rst_busy", {31'd0, bus.uart_rx_busy}, 0);
        check("rst_err",  {31'd0, bus.uart_rx_frame_err}, 0);
        rstn = 1'b1;
        idle(2 * CPB);

        // Single frame 0x55
        d0 = done_cnt; e0 = err_cnt; b0 = busy_cycles;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle(2 * CPB);
        bl = busy_cycles - b0;
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_err_count", err_cnt - e0, 0);
        check("t1_busy_len", {31'd0, (bl >= 9 * CPB) && (bl <= 10 * CPB)}, 1);
        $display("t1 busy cycles %0d", bl);

        // Back-to-back 0x00 then 0xFF with no idle gap
        d0 = done_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(2 * CPB);
        check("t2_done_count", done_cnt - d0, 2);
        check("t2_data", {24'd0, bus.uart_rx_data}, 32'hFF);

        // Short low glitch on an idle line
        d0 = done_cnt; e0 = err_cnt; b0 = busy_cycles;
        @(negedge clk); bus.uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        idle(3 * CPB);
        bl = busy_cycles - b0;
        check("t3_busy_brief", {31'd0, (bl > 0) && (bl < CPB)}, 1);
        check("t3_no_done", done_cnt - d0, 0);
        check("t3_no_err", err_cnt - e0, 0);
        check("t3_data_held", {24'd0, bus.uart_rx_data}, 32'hFF);

        // 0xA3 with a low stop bit, then the line stays low
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA3, 1'b0);
        repeat (CPB) @(negedge clk);
        b0 = busy_cycles;
        repeat (3 * CPB) @(negedge clk);
        check("t4_stuck_low_idle", busy_cycles - b0, 0);
        check("t4_err_count", err_cnt - e0, 1);
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_data_held", {24'd0, bus.uart_rx_data}, 32'hFF);
        idle(3 * CPB);

        // Reset during bit 4 of 0x3C, then a clean 0xC3
        d0 = done_cnt; e0 = err_cnt;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(((8'h3C >> i) & 8'h01) != 0);
        @(negedge clk); bus.uart_rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("t5_rst_data", {24'd0, bus.uart_rx_data}, 0);
        check("t5_rst_busy", {31'd0, bus.uart_rx_busy}, 0);
        check("t5_rst_done", {31'd0, bus.uart_rx_done}, 0);
        check("t5_rst_err",  {31'd0, bus.uart_rx_frame_err}, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        idle(3 * CPB);
        check("t5_abort_no_done", done_cnt - d0, 0);
        check("t5_abort_no_err", err_cnt - e0, 0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        idle(2 * CPB);
        check("t5_done_count", done_cnt - d0, 1);
        check("t5_data", {24'd0, bus.uart_rx_data}, 32'hC3);

        // Continuous incrementing stream of 300 bytes, wrapping through 0xFF
        d0 = done_cnt; e0 = err_cnt;
        for (int n = 0; n < 300; n++) begin
            exp_q.push_back(8'(n));
            send_frame(8'(n), 1'b1);
        end
        idle(2 * CPB);
        check("t6_done_count", done_cnt - d0, 300);
        check("t6_err_count", err_cnt - e0, 0);
        check("t6_last_data", {24'd0, bus.uart_rx_data}, 32'h2B);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
